// File: rtl/reg_write_arb_pkg.sv
// Shared types and constants for the register write arbiter.
//   state_e  : two-state arbiter FSM encoding (IDLE, GRANT)
//   WR_CNT_W : width of the completed-write counter
package reg_write_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int unsigned WR_CNT_W = 8;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin winner search.
//   req    : request vector
//   ptr    : index where the scan starts (highest priority)
//   winner : first set req bit at or above ptr, wrapping modulo REQ
// REQ must be a power of two so the index arithmetic wraps naturally.
module rr_pick #(
  parameter int unsigned REQ = 4
) (
  input  logic [REQ-1:0]         req,
  input  logic [$clog2(REQ)-1:0] ptr,
  output logic [$clog2(REQ)-1:0] winner
);

  localparam int unsigned PW = $clog2(REQ);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < REQ; k++) begin
      idx = ptr + PW'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter guarding writes to one shared N-bit register.
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   req    : per-requester write request, held until granted
//   wdata  : per-requester write data, requester i at [i*N +: N]
//   lock   : per-requester hold-grant request (REG_WRITE_ARB_LOCK_EN only)
//   gnt    : registered one-hot grant
//   owner  : current or last granted requester
//   busy   : high while a grant is active
//   q      : shared register contents
//   wr_cnt : completed-write counter, wraps
// Optional feature macro: REG_WRITE_ARB_LOCK_EN enables the lock port and
// bounded back-to-back writes (up to LOCK_MAX) by the current owner.
module reg_write_arbiter
  import reg_write_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned REQ      = 4
`ifdef REG_WRITE_ARB_LOCK_EN
  ,
  parameter int unsigned LOCK_MAX = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REQ-1:0]         req,
  input  logic [REQ*N-1:0]       wdata,
`ifdef REG_WRITE_ARB_LOCK_EN
  input  logic [REQ-1:0]         lock,
`endif
  output logic [REQ-1:0]         gnt,
  output logic [$clog2(REQ)-1:0] owner,
  output logic                   busy,
  output logic [N-1:0]           q,
  output logic [WR_CNT_W-1:0]    wr_cnt
);

  localparam int unsigned PW = $clog2(REQ);

  state_e        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic          wr_ok;
  logic          hold;

  rr_pick #(
    .REQ(REQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .winner(winner)
  );

  // A withdrawn request during GRANT aborts the write.
  assign wr_ok = req[owner];
  assign busy  = (state == GRANT);

`ifdef REG_WRITE_ARB_LOCK_EN
  localparam int unsigned LRW = $clog2(LOCK_MAX + 1);
  logic [LRW-1:0] run;

  // Stay in GRANT only if this write does not complete the allowed run.
  assign hold = wr_ok & lock[owner] & ((int'(run) + 1) < int'(LOCK_MAX));
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      ptr    <= '0;
      q      <= '0;
      wr_cnt <= '0;
`ifdef REG_WRITE_ARB_LOCK_EN
      run    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            gnt   <= {{(REQ-1){1'b0}}, 1'b1} << winner;
            owner <= winner;
`ifdef REG_WRITE_ARB_LOCK_EN
            run   <= '0;
`endif
          end
        end
        GRANT: begin
          if (wr_ok) begin
            q      <= wdata[owner*N +: N];
            wr_cnt <= wr_cnt + 1'b1;
          end
          if (hold) begin
`ifdef REG_WRITE_ARB_LOCK_EN
            run <= run + 1'b1;
`endif
          end else begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= owner + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (N=4, REQ=4): a transaction-level
// model checked every cycle plus directed literal expectations.
module tb_reg_write_arbiter;

  localparam int N        = 4;
  localparam int REQ      = 4;
  localparam int LOCK_MAX = 8;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic [3:0]  req   = 4'b0000;
  logic [15:0] wdata = 16'h0000;
`ifdef REG_WRITE_ARB_LOCK_EN
  logic [3:0]  lock  = 4'b0000;
`endif
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  q;
  logic [7:0]  wr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(
    .N       (N),
    .REQ     (REQ)
`ifdef REG_WRITE_ARB_LOCK_EN
    ,
    .LOCK_MAX(LOCK_MAX)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
`ifdef REG_WRITE_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q),
    .wr_cnt(wr_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: arbiter either idle or serving one owner; scan starts at ptr.
  int m_busy, m_owner, m_ptr, m_run, m_q, m_cnt;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < REQ; k++)
      if (r[(p + k) % REQ]) return (p + k) % REQ;
    return p;
  endfunction

  always @(posedge clk or negedge rst) begin
    int  w;
    bit  wrote, keep;
    if (!rst) begin
      m_busy <= 0; m_owner <= 0; m_ptr <= 0; m_run <= 0; m_q <= 0; m_cnt <= 0;
    end else if (m_busy == 0) begin
      if (req != 4'b0000) begin
        w = pick(req, m_ptr);
        m_busy  <= 1;
        m_owner <= w;
        m_run   <= 0;
      end
    end else begin
      wrote = req[m_owner];
      keep  = 1'b0;
`ifdef REG_WRITE_ARB_LOCK_EN
      keep  = wrote && lock[m_owner] && (m_run + 1 < LOCK_MAX);
`endif
      if (wrote) begin
        m_q   <= (wdata >> (m_owner * N)) & 16'hF;
        m_cnt <= (m_cnt + 1) % 256;
      end
      if (keep) m_run <= m_run + 1;
      else begin
        m_busy <= 0;
        m_ptr  <= (m_owner + 1) % REQ;
      end
    end
  end

  always @(negedge clk) begin
    check("model_gnt",   32'(gnt),    (m_busy != 0) ? (32'd1 << m_owner) : 32'd0);
    check("model_owner", 32'(owner),  32'(m_owner));
    check("model_busy",  32'(busy),   32'(m_busy));
    check("model_q",     32'(q),      32'(m_q));
    check("model_cnt",   32'(wr_cnt), 32'(m_cnt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all requests raised.
    rst = 1'b0;
    req = 4'b1111;
    step(2);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_cnt", 32'(wr_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    req = 4'b0000;
    rst = 1'b1;
    step(1);

    // Single request from requester 2.
    wdata = 16'h0A00;
    req   = 4'b0100;
    step(1);
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_busy", 32'(busy), 32'h1);
    step(1);
    check("single_q", 32'(q), 32'hA);
    check("single_cnt", 32'(wr_cnt), 32'h1);
    check("single_gnt_off", 32'(gnt), 32'h0);
    req = 4'b0000;

    // Fresh reset so the fairness run starts scanning at requester 0.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    wdata = 16'h4321;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("fair_gnt", 32'(gnt), 32'd1 << (i % 4));
      step(1);
      check("fair_q", 32'(q), 32'((i % 4) + 1));
    end
    check("fair_cnt", 32'(wr_cnt), 32'd5);
    req = 4'b0000;

    // Requester 1 withdraws during its grant.
    req = 4'b0010;
    step(1);
    check("wd_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step(1);
    check("wd_q", 32'(q), 32'h1);
    check("wd_cnt", 32'(wr_cnt), 32'd5);
    req = 4'b1111;
    step(1);
    check("wd_ptr_gnt", 32'(gnt), 32'h4);

    // Reset while busy, away from the clock edge.
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_q", 32'(q), 32'h0);
    #1;
    rst = 1'b1;
    req = 4'b0110;
    step(1);
    check("post_rst_gnt", 32'(gnt), 32'h2);
    step(1);
    req = 4'b0000;
    step(1);

`ifdef REG_WRITE_ARB_LOCK_EN
    // Locked run by requester 3, bounded at LOCK_MAX writes.
    rst = 1'b0;
    #1;
    rst   = 1'b1;
    wdata = 16'h9000;
    lock  = 4'b1000;
    req   = 4'b1000;
    step(1);
    check("lock_gnt0", 32'(gnt), 32'h8);
    req = 4'b1111;
    for (int i = 1; i < 8; i++) begin
      step(1);
      check("lock_gnt", 32'(gnt), 32'h8);
      check("lock_cnt", 32'(wr_cnt), 32'(i));
    end
    step(1);
    check("lock_rel_gnt", 32'(gnt), 32'h0);
    check("lock_rel_cnt", 32'(wr_cnt), 32'd8);
    check("lock_q", 32'(q), 32'h9);
    step(1);
    check("lock_next_gnt", 32'(gnt), 32'h1);
    lock = 4'b0000;
    req  = 4'b0000;
    step(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 4: data width of the shared register.
REQ-002 Parameter REQ, default 4: number of requesters (power of 2, >=2).
REQ-003 Parameter LOCK_MAX, default 8: maximum consecutive locked writes (used only with REG_WRITE_ARB_LOCK_EN).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 req  input  REQ  per-requester write request, level-held until granted.
REQ-007 wdata  input  REQ*N  per-requester write data; requester i occupies bits [i*N +: N].
REQ-008 lock  input  REQ  per-requester hold-grant request; present only with REG_WRITE_ARB_LOCK_EN.
REQ-009 gnt  output  REQ  one-hot grant, registered.
REQ-010 owner  output  clog2(REQ)  index of the current or last granted requester.
REQ-011 busy  output  1  high while state is GRANT.
REQ-012 q  output  N  shared register contents.
REQ-013 wr_cnt  output  8  count of completed writes, wraps 255->0.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-015 IDLE, |req=1 at an edge: winner = first set req bit scanning from ptr upward, modulo REQ; next state GRANT, gnt <= onehot(winner), owner <= winner.
REQ-016 IDLE, req=0: state, gnt, q, ptr unchanged.
REQ-017 GRANT edge, req[owner]=1: q <= wdata[owner], wr_cnt <= wr_cnt+1.
REQ-018 GRANT edge, req[owner]=0 (withdrawn): write aborted; q and wr_cnt unchanged.
REQ-019 GRANT edge without lock continuation: ptr <= owner+1 mod REQ, gnt <= 0, next state IDLE.
REQ-020 Latency: req sampled at edge k -> gnt high from k to k+1 -> q valid after edge k+1; minimum two cycles per write, one idle cycle between grants.
REQ-021 Requests arriving while in GRANT SHALL NOT change gnt or owner.
REQ-022 Any one requester SHALL wait at most REQ grant cycles (round-robin fairness).
REQ-023 busy SHALL equal (state == GRANT); gnt SHALL be zero in IDLE.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, gnt=0, owner=0, ptr=0, busy=0, q=0, wr_cnt=0, regardless of clk.
REQ-025 Reset asserted during GRANT SHALL abort the write, with no q update.
REQ-026 The first grant after reset release SHALL start scanning at requester 0.

Configuration
REQ-027 Macro REG_WRITE_ARB_LOCK_EN defined: lock port present; at a GRANT edge with req[owner]=1, lock[owner]=1 and lock run < LOCK_MAX, the write occurs and the FSM stays in GRANT with gnt held and ptr unchanged; when the run reaches LOCK_MAX writes, release is forced per REQ-019.
REQ-028 Macro REG_WRITE_ARB_LOCK_EN undefined: no lock port and no lock counter; behaviour exactly per REQ-015..REQ-023.

Structure
REQ-029 Package reg_write_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT) and the wr_cnt width constant.
REQ-030 The round-robin winner search SHALL be a separate sub-module rr_pick (inputs req and ptr, output winner index), instantiated once.

Verification (N=4, REQ=4)
REQ-031 Reset: rst=0 with req=4'b1111 -> gnt=0, q=0, wr_cnt=0, busy=0.
REQ-032 Single request: req=4'b0100, wdata[2]=4'b1010 -> gnt=4'b0100 for one cycle; q=4'b1010 after the next edge; wr_cnt=1.
REQ-033 Fairness: req=4'b1111 held -> grant order 0,1,2,3,0; q follows each requester's wdata; wr_cnt=5.
REQ-034 Withdraw: req[1] dropped during its GRANT cycle -> q unchanged, wr_cnt unchanged, ptr advances to 2.
REQ-035 Mid-operation reset: rst=0 while busy=1 -> gnt=0 immediately; the next grant goes to the lowest-index requester.
REQ-036 Lock build: requester 3 with lock=1, req=1, and req=4'b1111 -> gnt=4'b1000 for 8 consecutive writes, then the next grant goes to requester 0.
